insn_queue: RTL

- Small fetch-to-decode instruction queue. It sits directly downstream of the fetch stage and upstream of decode.
- Buffers {pc, insn} packets with valid/ready handshakes on both sides, so fetch can run ahead while decode stalls.
- A single-cycle flush discards all buffered packets on a control-flow redirect.

---
 rtl/core_pkg.sv | 15 +
 rtl/insn_queue.sv | 94 +++++++++
 2 files changed

// File: rtl/core_pkg.sv
// Shared fetch/decode definitions: the packet layout handed between the two stages
// and the instruction decode substitutes when no packet is available.
package core_pkg;

    localparam int PC_W   = 32;
    localparam int INSN_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INSN_W-1:0] insn;
    } fetch_pkt_t;

    localparam logic [INSN_W-1:0] INSN_NOP = 32'h0000_0013;

endpackage

// File: rtl/insn_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of {pc, insn}
// with valid/ready on both sides and a single-cycle flush for redirects.
module insn_queue
    import core_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [AWIDTH-1:0]          in_pc_i,
    input  logic [DWIDTH-1:0]          in_insn_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [AWIDTH-1:0]          out_pc_o,
    output logic [DWIDTH-1:0]          out_insn_o,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AWIDTH-1:0] pc_mem   [DEPTH];
    logic [DWIDTH-1:0] insn_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Handshake flags depend on registered occupancy only, so neither ready
    // nor valid has a combinational path from the opposite side.
    assign in_ready_o  = (count_q != FULL_CNT);
    assign out_valid_o = (count_q != '0);
    assign count_o     = count_q;

    assign push = in_valid_i  && in_ready_o  && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;

    assign out_pc_o   = out_valid_o ? pc_mem[rd_ptr_q]   : '0;
    assign out_insn_o = out_valid_o ? insn_mem[rd_ptr_q] : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            pc_mem[wr_ptr_q]   <= in_pc_i;
            insn_mem[wr_ptr_q] <= in_insn_i;
        end
    end

    a_count_max : assert property (@(posedge clk) disable iff (!rst)
        count_q <= FULL_CNT);

    a_count_ptrs : assert property (@(posedge clk) disable iff (!rst)
        (count_q == FULL_CNT) ? (wr_ptr_q == rd_ptr_q)
                              : (count_q[PW-1:0] == PW'(wr_ptr_q - rd_ptr_q)));

endmodule
